// File: rtl/risc_uart_tx_pkg.sv
// Shared register map, STATUS field positions and FSM encodings for risc_uart_tx.
// Build option: `UART_TX_PARITY_EN adds an even-parity bit to every frame.
package risc_uart_tx_pkg;

  localparam logic [15:0] UART_TXDATA_OFS = 16'd0;
  localparam logic [15:0] UART_STATUS_OFS = 16'd1;

  localparam int ST_FULL_BIT  = 0;
  localparam int ST_EMPTY_BIT = 1;
  localparam int ST_CNT_LSB   = 2;
  localparam int ST_OVF_BIT   = 5;
  localparam int ST_PAR_BIT   = 15;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_e;

`ifdef UART_TX_PARITY_EN
  localparam logic PARITY_BUILD = 1'b1;
`else
  localparam logic PARITY_BUILD = 1'b0;
`endif

  function automatic logic [15:0] status_word(input logic       ovf,
                                              input logic [2:0] cnt,
                                              input logic       empty,
                                              input logic       full,
                                              input logic       par);
    logic [15:0] s;
    s                       = '0;
    s[ST_FULL_BIT]          = full;
    s[ST_EMPTY_BIT]         = empty;
    s[ST_CNT_LSB +: 3]      = cnt;
    s[ST_OVF_BIT]           = ovf;
    s[ST_PAR_BIT]           = par;
    return s;
  endfunction

endpackage

// File: rtl/risc_uart_tx_fifo.sv
// Synchronous word FIFO feeding the UART transmitter; head word is visible on dout_o.
// Push while full and pop while empty are ignored; reset flushes the contents.
module risc_tx_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  din_i,
  output logic [W-1:0]  dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;
  logic          push_ok, pop_ok;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rptr_q];
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= din_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + AW'(1);
      if (pop_ok)  rptr_q <= rptr_q + AW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/risc_uart_tx.sv
// Memory-mapped UART transmitter: buffers 16-bit stores and sends each as two bytes, low first.
// Build option: `UART_TX_PARITY_EN inserts an even-parity bit after the data bits.
module risc_uart_tx
  import risc_uart_tx_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [15:0] ADDR_BASE    = 16'hFF00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_write_en,
  input  logic        mem_read,
  input  logic [15:0] addr,
  input  logic [15:0] write_data,
  output logic [15:0] read_data,
  output logic        tx,
  output logic        busy
);

  localparam int          CW          = $clog2(FIFO_DEPTH) + 1;
  localparam int          BW          = $clog2(CLKS_PER_BIT);
  localparam logic [15:0] TXDATA_ADDR = ADDR_BASE + UART_TXDATA_OFS;
  localparam logic [15:0] STATUS_ADDR = ADDR_BASE + UART_STATUS_OFS;

  tx_state_e     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic          byte_sel_q, byte_sel_d;
  logic [15:0]   word_q, word_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          ovf_q, ovf_d;

  logic          wr_txdata, rd_status, push_ok, drop, pop, tick;
  logic [15:0]   f_dout;
  logic          f_full, f_empty;
  logic [CW-1:0] f_count, cnt_nxt;
  logic [4:0]    cnt_ext;
  logic [2:0]    cnt_sat;
  logic [7:0]    next_byte;

  assign wr_txdata = mem_write_en && (addr == TXDATA_ADDR);
  assign rd_status = mem_read && (addr == STATUS_ADDR);
  // Full is the pre-edge value, so a same-cycle pop never rescues a push.
  assign push_ok   = wr_txdata & ~f_full;
  assign drop      = wr_txdata & f_full;
  assign tick      = (baud_q == BW'(CLKS_PER_BIT - 1));

  risc_tx_fifo #(.DEPTH(FIFO_DEPTH), .W(16)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_ok),
    .pop_i   (pop),
    .din_i   (write_data),
    .dout_o  (f_dout),
    .full_o  (f_full),
    .empty_o (f_empty),
    .count_o (f_count)
  );

  assign cnt_ext = 5'(f_count);
  assign cnt_sat = (cnt_ext > 5'd7) ? 3'd7 : cnt_ext[2:0];

  always_comb begin
    read_data = '0;
    if (rd_status) read_data = status_word(ovf_q, cnt_sat, f_empty, f_full, PARITY_BUILD);
  end

  // A fresh drop takes priority over the clear-on-read.
  assign ovf_d = drop | (ovf_q & ~rd_status);

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    byte_sel_d = byte_sel_q;
    word_d     = word_q;
    pop        = 1'b0;
    if (state_q != TX_IDLE) baud_d = tick ? '0 : baud_q + BW'(1);
    case (state_q)
      TX_IDLE: begin
        baud_d = '0;
        if (!f_empty) begin
          pop        = 1'b1;
          word_d     = f_dout;
          byte_sel_d = 1'b0;
          state_d    = TX_START;
        end
      end
      TX_START: begin
        if (tick) begin
          state_d = TX_DATA;
          bit_d   = 3'd0;
        end
      end
      TX_DATA: begin
        if (tick) begin
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = TX_PARITY;
`else
            state_d = TX_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      TX_PARITY: begin
        if (tick) state_d = TX_STOP;
      end
      TX_STOP: begin
        if (tick) begin
          if (!byte_sel_q) begin
            byte_sel_d = 1'b1;
            state_d    = TX_START;
          end else if (!f_empty) begin
            pop        = 1'b1;
            word_d     = f_dout;
            byte_sel_d = 1'b0;
            state_d    = TX_START;
          end else begin
            state_d = TX_IDLE;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase

    // Line level is derived from the next state so tx is a clean flop output.
    next_byte = byte_sel_d ? word_d[15:8] : word_d[7:0];
    case (state_d)
      TX_START:  tx_d = 1'b0;
      TX_DATA:   tx_d = next_byte[bit_d];
      TX_PARITY: tx_d = ^next_byte;
      default:   tx_d = 1'b1;
    endcase

    cnt_nxt = f_count + CW'(push_ok) - CW'(pop);
    busy_d  = (state_d != TX_IDLE) | (cnt_nxt != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= TX_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      byte_sel_q <= 1'b0;
      word_q     <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      byte_sel_q <= byte_sel_d;
      word_q     <= word_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      ovf_q      <= ovf_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;

endmodule
